// File: rtl/cache_refill_ctrl.sv
// Miss-handling engine: writes back a dirty victim line, refills the missing line beat by beat, stalls the pipeline meanwhile.
// Optional build macro CRITICAL_WORD_FIRST_EN starts the fill at the missed word and wraps around the line.
module cache_refill_ctrl #(
  parameter int WIDTH = 32,
  parameter int LINE_WORDS = 4,
  localparam int IDXW = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss,
  input  logic             dirty,
  input  logic [WIDTH-1:0] miss_addr,
  input  logic [WIDTH-1:0] victim_addr,
  output logic [IDXW-1:0]  victim_idx,
  input  logic [WIDTH-1:0] victim_word,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             fill_we,
  output logic [IDXW-1:0]  fill_idx,
  output logic [WIDTH-1:0] fill_word,
  output logic             fill_done,
  output logic             stall,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

  localparam logic [WIDTH-1:0] LINE_MASK = WIDTH'(LINE_WORDS * 4 - 1);
  localparam logic [IDXW-1:0]  LAST_CNT  = IDXW'(LINE_WORDS - 1);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] base_miss_q, base_miss_d;
  logic [WIDTH-1:0] base_vict_q, base_vict_d;
  logic [IDXW-1:0]  idx_w;

  function automatic logic [WIDTH-1:0] word_off(input logic [IDXW-1:0] i);
    return {{(WIDTH-IDXW-2){1'b0}}, i, 2'b00};
  endfunction

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDXW-1:0] crit_q, crit_d;
  assign idx_w = crit_q + cnt_q;
`else
  assign idx_w = cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      base_miss_q <= '0;
      base_vict_q <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_miss_q <= base_miss_d;
      base_vict_q <= base_vict_d;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_q      <= crit_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_miss_d = base_miss_q;
    base_vict_d = base_vict_q;
`ifdef CRITICAL_WORD_FIRST_EN
    crit_d      = crit_q;
`endif
    victim_idx  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_we     = 1'b0;
    fill_idx    = '0;
    fill_word   = '0;
    fill_done   = 1'b0;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = miss;
        if (miss) begin
          base_miss_d = miss_addr & ~LINE_MASK;
          base_vict_d = victim_addr & ~LINE_MASK;
          cnt_d       = '0;
`ifdef CRITICAL_WORD_FIRST_EN
          crit_d      = miss_addr[IDXW+1:2];
`endif
          state_d     = dirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        stall      = 1'b1;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = base_vict_q + word_off(cnt_q);
        victim_idx = cnt_q;
        mem_wdata  = victim_word;
        if (mem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = base_miss_q + word_off(idx_w);
        fill_we   = mem_ready;
        fill_idx  = idx_w;
        fill_word = mem_rdata;
        if (mem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_DONE;
        end
      end
      S_DONE: begin
        stall     = 1'b1;
        fill_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A reset cycle must not issue or complete any beat, even mid-refill.
    if (!rst) begin
      victim_idx = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      fill_we    = 1'b0;
      fill_idx   = '0;
      fill_word  = '0;
      fill_done  = 1'b0;
      stall      = 1'b0;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling engine directly downstream of the direct-mapped data cache, between the cache and the beat-wise main-memory port.
- On a cache miss it writes back the dirty victim line (if any), fetches the missing line one word per beat, and writes each word into the cache.
- It stalls the pipeline for the whole refill.
- The cache replays the access after the refill and hits.

Parameters:
WIDTH, 32, data/address width in bits
LINE_WORDS, 4, words per cache line; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst==0 at a rising edge resets)
miss  input  1  cache lookup missed this cycle
dirty  input  1  victim line is dirty; sampled with miss
miss_addr  input  WIDTH  byte address of the missing access
victim_addr  input  WIDTH  byte address of the victim line
victim_idx  output  log2(LINE_WORDS)  victim word index the cache must present
victim_word  input  WIDTH  victim word at victim_idx, combinational from cache
mem_req  output  1  memory beat request
mem_we  output  1  1 = write beat, 0 = read beat
mem_addr  output  WIDTH  word-aligned beat byte address
mem_wdata  output  WIDTH  write-beat data
mem_ready  input  1  current beat completes this cycle
mem_rdata  input  WIDTH  read data, valid when mem_ready && !mem_we
fill_we  output  1  write fill_word into the cache line
fill_idx  output  log2(LINE_WORDS)  fill word index
fill_word  output  WIDTH  fill data
fill_done  output  1  one-cycle pulse: line valid, tag updated, clean
stall  output  1  hold the pipeline (IF/ID/EX/MEM)

Behaviour:
- States: IDLE, WB, FILL, DONE. After reset: state=IDLE; beat counter=0; all outputs 0 except mem_addr/mem_wdata/fill_word, which are 0.
- IDLE, with miss=1:
  - Latch base_miss = miss_addr with its low log2(LINE_WORDS)+2 bits cleared.
  - Latch base_vict = victim_addr aligned the same way.
  - Clear the beat counter.
  - Go to WB if dirty=1, else FILL.
  - With miss=0, stay in IDLE.
- stall = (state != IDLE) || (state==IDLE && miss). Stall is therefore asserted in the same cycle as the miss.
- WB:
  - mem_req=1, mem_we=1, mem_addr=base_vict+4*cnt.
  - victim_idx=cnt; mem_wdata=victim_word.
  - On mem_ready: cnt++. On the last beat (cnt==LINE_WORDS-1), go to FILL with cnt=0.
  - With mem_ready=0, hold all outputs stable. There is no timeout.
- FILL:
  - mem_req=1, mem_we=0, mem_addr=base_miss+4*idx.
  - fill_we=mem_ready; fill_idx=idx; fill_word=mem_rdata (combinational pass-through in the ready cycle).
  - On mem_ready: cnt++. On the last beat, go to DONE.
- DONE:
  - fill_done=1, stall=1, mem_req=0. Next state is IDLE.
  - The cache's replayed access hits in the following cycle.
- miss is ignored outside IDLE. A miss present in DONE is not latched.
- Address arithmetic is modulo 2^WIDTH. cnt and idx wrap modulo LINE_WORDS.
- Latency: a clean miss with mem_ready always 1 keeps stall high for LINE_WORDS+2 cycles (miss cycle + LINE_WORDS fill beats + DONE). A dirty miss adds LINE_WORDS.
- Reset mid-operation:
  - Return to IDLE immediately and drop mem_req in the reset cycle.
  - No fill_done is produced.
  - Partial cache contents are the cache's responsibility; it invalidates on reset.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
CRITICAL_WORD_FIRST_EN.
- Defined: the fill starts at word w = miss_addr[log2(LINE_WORDS)+1:2] and proceeds idx=(w+cnt) mod LINE_WORDS. This wraps, e.g. 2,3,0,1 for LINE_WORDS=4.
- Not defined: idx=cnt, i.e. the fill runs 0..LINE_WORDS-1.
- Write-back order is always 0..LINE_WORDS-1.
- Beat count and stall timing are identical in both builds.

Test Plan:
1. Clean miss, miss_addr=0x0000_1014, LINE_WORDS=4, mem_ready=1 -> read beats at 0x1010, 0x1014, 0x1018, 0x101C; fill_idx 0..3; stall high for 6 cycles; fill_done single pulse in cycle 6.
2. Dirty miss, victim_addr=0x0000_2000, miss_addr=0x0000_3008 -> 4 write beats at 0x2000..0x200C with mem_wdata=victim_word for victim_idx 0..3; then 4 reads at 0x3000..0x300C; stall high for 10 cycles.
3. Clean miss with mem_ready pattern 1,0,0,1,1,0,1 -> mem_addr/mem_we held stable while ready=0; exactly 4 fill_we pulses; fill_done one cycle after the 4th.
4. Reset (rst=0) during the FILL beat at cnt=2 -> next cycle: mem_req=0, stall=0, fill_we=0, no fill_done; a new miss after rst=1 starts from cnt=0.
5. CRITICAL_WORD_FIRST_EN defined, miss_addr=0x0000_1018 -> fill_idx order 2,3,0,1; mem_addr order 0x1018, 0x101C, 0x1010, 0x1014.
6. miss held at 1 continuously through DONE -> no second refill begins until IDLE. In IDLE, miss=1 restarts the sequence and stall stays high without a gap.
